// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: gameplay countdown with 1 Hz prescaler, BCD display digits, bonus time and low-time blink
module game_timer_ctrl #(
    parameter int CLK_FREQ    = 31500000,
    parameter int LEVEL1_SECS = 120,
    parameter int LEVEL2_SECS = 90,
    parameter int WARN_SECS   = 10,
    parameter int BONUS_SECS  = 15
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [1:0] level_sel,
    input  logic       load,
    input  logic       game_on,
    input  logic       pause,
    input  logic       bonus,
    output logic       one_sec_pulse,
    output logic [9:0] secs_left,
    output logic [3:0] min_bcd,
    output logic [3:0] sec_tens_bcd,
    output logic [3:0] sec_ones_bcd,
    output logic       timer_ended,
    output logic       warning,
    output logic       blink
);
    localparam int CW       = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int MAX_SECS = 599;
    localparam int B_MIN    = BONUS_SECS / 60;
    localparam int B_TENS   = (BONUS_SECS % 60) / 10;
    localparam int B_ONES   = BONUS_SECS % 10;
    localparam int L1_MIN   = LEVEL1_SECS / 60;
    localparam int L1_TENS  = (LEVEL1_SECS % 60) / 10;
    localparam int L1_ONES  = LEVEL1_SECS % 10;
    localparam int L2_MIN   = LEVEL2_SECS / 60;
    localparam int L2_TENS  = (LEVEL2_SECS % 60) / 10;
    localparam int L2_ONES  = LEVEL2_SECS % 10;

    typedef enum logic [2:0] {IDLE, LOADED, RUNNING, PAUSED, EXPIRED} state_t;

    state_t        state, nxt_state;
    logic [CW-1:0] cnt;
    logic          tick, bonus_en, dec, sat, lvl2, nxt_warn;
    logic [9:0]    nxt_secs;
    logic [3:0]    nxt_min, nxt_tens, nxt_ones;
    int            sum, ones_i, tens_i, min_i;

    assign one_sec_pulse = (cnt == CW'(CLK_FREQ - 1));

    always_comb begin
        tick     = one_sec_pulse && (state == RUNNING);
        bonus_en = bonus && !load && (state inside {LOADED, RUNNING, PAUSED});
        // a tick at zero only counts when a bonus lands with it
        dec      = tick && (secs_left != '0 || bonus_en);
        lvl2     = (level_sel == 2'd2);
        sum      = int'(secs_left) + (bonus_en ? BONUS_SECS : 0) - (dec ? 1 : 0);
        ones_i   = int'(sec_ones_bcd) + (bonus_en ? B_ONES : 0) - (dec ? 1 : 0);
        tens_i   = int'(sec_tens_bcd) + (bonus_en ? B_TENS : 0) + (ones_i < 0 ? -1 : (ones_i > 9 ? 1 : 0));
        ones_i   = ones_i < 0 ? ones_i + 10 : (ones_i > 9 ? ones_i - 10 : ones_i);
        min_i    = int'(min_bcd) + (bonus_en ? B_MIN : 0) + (tens_i < 0 ? -1 : (tens_i > 5 ? 1 : 0));
        tens_i   = tens_i < 0 ? tens_i + 6 : (tens_i > 5 ? tens_i - 6 : tens_i);
        sat      = sum > MAX_SECS;
        nxt_secs = load ? (lvl2 ? 10'(LEVEL2_SECS) : 10'(LEVEL1_SECS)) : (sat ? 10'(MAX_SECS) : 10'(sum));
        nxt_min  = load ? (lvl2 ? 4'(L2_MIN) : 4'(L1_MIN)) : (sat ? 4'd9 : 4'(min_i));
        nxt_tens = load ? (lvl2 ? 4'(L2_TENS) : 4'(L1_TENS)) : (sat ? 4'd5 : 4'(tens_i));
        nxt_ones = load ? (lvl2 ? 4'(L2_ONES) : 4'(L1_ONES)) : (sat ? 4'd9 : 4'(ones_i));
        nxt_state = state;
        case (state)
            LOADED:  nxt_state = (game_on && !pause) ? RUNNING : LOADED;
            RUNNING: nxt_state = (secs_left == '0 && !bonus_en) ? EXPIRED :
                                 ((pause || !game_on) ? PAUSED : RUNNING);
            PAUSED:  nxt_state = (game_on && !pause) ? RUNNING : PAUSED;
            default: nxt_state = state;
        endcase
        if (load) nxt_state = LOADED;
        nxt_warn = !load && (nxt_state != EXPIRED) && (nxt_secs != '0) && (int'(nxt_secs) <= WARN_SECS);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state        <= IDLE;
            cnt          <= '0;
            secs_left    <= '0;
            min_bcd      <= '0;
            sec_tens_bcd <= '0;
            sec_ones_bcd <= '0;
            timer_ended  <= 1'b0;
            warning      <= 1'b0;
            blink        <= 1'b0;
        end else begin
            state        <= nxt_state;
            cnt          <= (load || one_sec_pulse) ? '0 : cnt + 1'b1;
            secs_left    <= nxt_secs;
            min_bcd      <= nxt_min;
            sec_tens_bcd <= nxt_tens;
            sec_ones_bcd <= nxt_ones;
            timer_ended  <= (nxt_state == EXPIRED);
            warning      <= nxt_warn;
            blink        <= nxt_warn ? (blink ^ (warning && one_sec_pulse)) : 1'b0;
        end
    end
endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb_game_timer_ctrl: directed vector table plus multi-cycle sequences for game_timer_ctrl
module tb_game_timer_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetN, load, game_on, pause, bonus;
    logic [1:0] level_sel;
    logic       a_pulse, a_ended, a_warn, a_blink, b_pulse, b_ended, b_warn, b_blink;
    logic [9:0] a_secs, b_secs, prev;
    logic [3:0] a_min, a_tens, a_ones, b_min, b_tens, b_ones;
    int         errors = 0, checks = 0;
    int         found, pulses, bad, ew, eb;

    game_timer_ctrl #(.CLK_FREQ(4)) dut_a (
        .clk(clk), .resetN(resetN), .level_sel(level_sel), .load(load), .game_on(game_on),
        .pause(pause), .bonus(bonus), .one_sec_pulse(a_pulse), .secs_left(a_secs),
        .min_bcd(a_min), .sec_tens_bcd(a_tens), .sec_ones_bcd(a_ones),
        .timer_ended(a_ended), .warning(a_warn), .blink(a_blink)
    );

    game_timer_ctrl #(.CLK_FREQ(4), .LEVEL1_SECS(3), .LEVEL2_SECS(11)) dut_b (
        .clk(clk), .resetN(resetN), .level_sel(level_sel), .load(load), .game_on(game_on),
        .pause(pause), .bonus(bonus), .one_sec_pulse(b_pulse), .secs_left(b_secs),
        .min_bcd(b_min), .sec_tens_bcd(b_tens), .sec_ones_bcd(b_ones),
        .timer_ended(b_ended), .warning(b_warn), .blink(b_blink)
    );

    typedef struct {
        logic       rn;
        logic [1:0] lvl;
        logic       ld, go, ps, bn;
        logic       pulse;
        logic [9:0] secs;
        logic [3:0] mn, tn, on;
        logic       ended, warn;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic rn, input logic [1:0] lvl, input logic ld, go, ps, bn,
                                input logic pulse, input logic [9:0] secs, input logic [3:0] mn, tn, on,
                                input logic ended, warn);
        vec_t v;
        v.rn = rn; v.lvl = lvl; v.ld = ld; v.go = go; v.ps = ps; v.bn = bn;
        v.pulse = pulse; v.secs = secs; v.mn = mn; v.tn = tn; v.on = on; v.ended = ended; v.warn = warn;
        return v;
    endfunction

    task automatic drive(input logic rn, input logic [1:0] lvl, input logic ld, go, ps, bn);
        resetN = rn; level_sel = lvl; load = ld; game_on = go; pause = ps; bonus = bn;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //           rn lvl ld go ps bn | pulse secs m t o end warn
        vecs[0]  = mk(0, 1, 0, 0, 0, 0,   0,   0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 0, 0, 0,   0, 120, 2, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 1, 0, 0,   0, 120, 2, 0, 0, 0, 0);
        vecs[3]  = mk(1, 1, 0, 1, 0, 0,   0, 120, 2, 0, 0, 0, 0);
        vecs[4]  = mk(1, 1, 0, 1, 0, 0,   1, 120, 2, 0, 0, 0, 0);
        vecs[5]  = mk(1, 1, 0, 1, 0, 0,   0, 119, 1, 5, 9, 0, 0);
        vecs[6]  = mk(1, 2, 1, 0, 0, 0,   0,  90, 1, 3, 0, 0, 0);
        vecs[7]  = mk(1, 3, 1, 0, 0, 0,   0, 120, 2, 0, 0, 0, 0);
        vecs[8]  = mk(1, 1, 1, 0, 0, 1,   0, 120, 2, 0, 0, 0, 0);
        vecs[9]  = mk(1, 1, 0, 0, 0, 1,   0, 135, 2, 1, 5, 0, 0);
        vecs[10] = mk(1, 1, 0, 0, 0, 0,   0, 135, 2, 1, 5, 0, 0);
        vecs[11] = mk(1, 1, 0, 0, 0, 0,   1, 135, 2, 1, 5, 0, 0);
        vecs[12] = mk(1, 1, 0, 0, 0, 0,   0, 135, 2, 1, 5, 0, 0);
        vecs[13] = mk(0, 1, 0, 1, 0, 0,   0,   0, 0, 0, 0, 0, 0);
        vecs[14] = mk(1, 1, 0, 0, 0, 1,   0,   0, 0, 0, 0, 0, 0);
        vecs[15] = mk(1, 2, 1, 1, 1, 0,   0,  90, 1, 3, 0, 0, 0);
        vecs[16] = mk(1, 2, 0, 1, 1, 0,   0,  90, 1, 3, 0, 0, 0);
        vecs[17] = mk(1, 2, 0, 1, 1, 0,   0,  90, 1, 3, 0, 0, 0);
        vecs[18] = mk(1, 2, 0, 1, 1, 0,   1,  90, 1, 3, 0, 0, 0);
        vecs[19] = mk(1, 2, 0, 1, 1, 0,   0,  90, 1, 3, 0, 0, 0);

        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rn, vecs[i].lvl, vecs[i].ld, vecs[i].go, vecs[i].ps, vecs[i].bn);
            chk($sformatf("vec%0d", i),
                {a_pulse, a_secs, a_min, a_tens, a_ones, a_ended, a_warn},
                {vecs[i].pulse, vecs[i].secs, vecs[i].mn, vecs[i].tn, vecs[i].on, vecs[i].ended, vecs[i].warn});
        end

        // bonus saturation at 9:59, then again from 590
        drive(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 32; i++) drive(1, 1, 0, 0, 0, 1);
        chk("bonus_sat_loaded", {a_secs, a_min, a_tens, a_ones}, {10'd599, 4'd9, 4'd5, 4'd9});
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            drive(1, 1, 0, 1, 0, 0);
            if (a_secs == 10'd590) found = 1;
        end
        chk("reach_590", found, 1);
        drive(1, 1, 0, 1, 0, 1);
        chk("bonus_590", {a_secs, a_min, a_tens, a_ones}, {10'd599, 4'd9, 4'd5, 4'd9});
        drive(1, 1, 0, 1, 0, 1);
        chk("bonus_599", {a_secs, a_min, a_tens, a_ones}, {10'd599, 4'd9, 4'd5, 4'd9});

        // bonus coincident with a tick at 100
        drive(1, 1, 1, 1, 0, 0);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            drive(1, 1, 0, 1, 0, 0);
            if (a_secs == 10'd100 && a_pulse) found = 1;
        end
        chk("reach_100_pulse", found, 1);
        drive(1, 1, 0, 1, 0, 1);
        chk("bonus_tick_100", {a_secs, a_min, a_tens, a_ones}, {10'd114, 4'd1, 4'd5, 4'd4});

        // pause freezes the count but not the prescaler
        drive(1, 1, 1, 1, 0, 0);
        for (int i = 0; i < 10 && a_secs == 10'd120; i++) drive(1, 1, 0, 1, 0, 0);
        chk("pause_start", a_secs, 10'd119);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1, 1, 0, 1, 1, 0);
            pulses += int'(a_pulse);
        end
        chk("pause_frozen", a_secs, 10'd119);
        chk("pause_pulses", pulses, 3);
        for (int i = 0; i < 8 && a_secs == 10'd119; i++) drive(1, 1, 0, 1, 0, 0);
        chk("pause_resume", {a_secs, a_min, a_tens, a_ones}, {10'd118, 4'd1, 4'd5, 4'd8});

        // run to zero on the 3 s budget and hold expiry
        drive(1, 1, 1, 1, 0, 0);
        chk("b_load3", b_secs, 10'd3);
        for (int k = 2; k >= 0; k--) begin
            prev = b_secs;
            for (int i = 0; i < 8 && b_secs == prev; i++) drive(1, 1, 0, 1, 0, 0);
            chk($sformatf("b_count%0d", k), b_secs, 10'(k));
        end
        chk("b_not_ended_at_0", b_ended, 1'b0);
        drive(1, 1, 0, 1, 0, 0);
        chk("b_ended", {b_ended, b_warn, b_blink}, 3'b100);
        bad = 0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1, 1, 0, 1, 0, 1);
            bad += int'(!b_ended || b_secs != 10'd0);
            pulses += int'(b_pulse);
        end
        chk("b_ended_hold", bad, 0);
        chk("b_hold_pulses", pulses, 10);
        drive(1, 1, 1, 1, 0, 0);
        chk("b_reload", {b_ended, b_secs}, {1'b0, 10'd3});

        // warning and blink over the last ten seconds of an 11 s budget
        drive(1, 2, 1, 1, 0, 0);
        chk("w_load11", {b_secs, b_warn, b_blink}, {10'd11, 1'b0, 1'b0});
        for (int k = 10; k >= 0; k--) begin
            prev = b_secs;
            for (int i = 0; i < 8 && b_secs == prev; i++) drive(1, 2, 0, 1, 0, 0);
            ew = (k > 0) ? 1 : 0;
            eb = (k > 0 && ((10 - k) % 2) == 1) ? 1 : 0;
            chk($sformatf("warn_%0d", k), {b_secs, b_warn, b_blink}, {10'(k), ew[0], eb[0]});
        end
        drive(1, 2, 0, 1, 0, 0);
        chk("warn_expired", {b_ended, b_warn, b_blink}, 3'b100);

        // synchronous reset in the middle of a run
        drive(1, 2, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) drive(1, 2, 0, 1, 0, 0);
        drive(0, 2, 0, 1, 0, 0);
        chk("rst_a", {a_pulse, a_secs, a_min, a_tens, a_ones, a_ended, a_warn, a_blink}, 32'd0);
        chk("rst_b", {b_pulse, b_secs, b_min, b_tens, b_ones, b_ended, b_warn, b_blink}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
